// File: rtl/countdown_pkg.sv
// Shared state encoding, digit limits and preset clamping for the M:SS.cc countdown.
package countdown_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUNNING = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  localparam logic [3:0] CS_MAX       = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Forces every field of a BCD preset into its legal range so the digits stay displayable.
  function automatic logic [19:0] clamp_preset(input logic [19:0] p, input logic [3:0] max_min);
    logic [3:0] mn, st, so, ct, co;
    mn = (p[19:16] > max_min)      ? max_min      : p[19:16];
    st = (p[15:12] > SEC_TENS_MAX) ? SEC_TENS_MAX : p[15:12];
    so = (p[11:8]  > SEC_ONES_MAX) ? SEC_ONES_MAX : p[11:8];
    ct = (p[7:4]   > CS_MAX)       ? CS_MAX       : p[7:4];
    co = (p[3:0]   > CS_MAX)       ? CS_MAX       : p[3:0];
    return {mn, st, so, ct, co};
  endfunction

endpackage

// File: rtl/countdown_sequencer_bcd_down_digit.sv
// One loadable BCD down-counting digit; borrow_out requests a decrement from the next digit up.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] value,
  output logic       borrow_out
);

  assign borrow_out = dec_en && (value == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (dec_en) begin
      value <= (value == 4'd0) ? MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Run/pause/clear controller for the 5-digit M:SS.cc countdown; digits feed the hex decoders directly.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int MAX_MIN     = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [19:0] preset,
  output logic [3:0]  digit4,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        running,
  output logic        paused,
  output logic        expired,
  output logic        out_pulse
);

  localparam logic [3:0] MIN_MAX = 4'(MAX_MIN);

  logic [1:0]  state, state_nxt;
  logic [19:0] shadow;
  logic [19:0] clamped;
  logic [19:0] cur;
  logic [19:0] load_val;
  logic        load, dec, expire;
  logic        b0, b1, b2, b3, b4;

  assign clamped = clamp_preset(preset, MIN_MAX);
  assign cur     = {digit4, digit3, digit2, digit1, digit0};

  // Strict command priority: clear > pause > start > tick.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = clamped;
    dec       = 1'b0;
    expire    = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      load      = 1'b1;
      load_val  = 20'd0;
    end else if (pause) begin
      if (state == RUNNING) state_nxt = PAUSED;
    end else if (start && (state == IDLE || state == EXPIRED)) begin
      if (clamped != 20'd0) begin
        load      = 1'b1;
        state_nxt = RUNNING;
      end
    end else if (start && state == PAUSED) begin
      state_nxt = RUNNING;
    end else if (tick && state == RUNNING) begin
      // Zero while RUNNING only occurs after an auto-reload expiry: this tick reloads instead.
      if (cur == 20'd0) begin
        if (AUTO_RELOAD != 0) begin
          load     = 1'b1;
          load_val = shadow;
        end
      end else begin
        dec = 1'b1;
        if (cur == 20'h00001) begin
          expire = 1'b1;
          if (AUTO_RELOAD == 0) state_nxt = EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      paused    <= 1'b0;
      expired   <= 1'b0;
      out_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      running   <= (state_nxt == RUNNING);
      paused    <= (state_nxt == PAUSED);
      expired   <= (state_nxt == EXPIRED);
      out_pulse <= expire;
    end
  end

  always_ff @(posedge clock) begin
    if (load && !clear && state != RUNNING) shadow <= clamped;
  end

  bcd_down_digit #(.MAX(CS_MAX)) u_cs_ones (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val[3:0]),
    .dec_en(dec), .value(digit0), .borrow_out(b0)
  );

  bcd_down_digit #(.MAX(CS_MAX)) u_cs_tens (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val[7:4]),
    .dec_en(b0), .value(digit1), .borrow_out(b1)
  );

  bcd_down_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val[11:8]),
    .dec_en(b1), .value(digit2), .borrow_out(b2)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val[15:12]),
    .dec_en(b2), .value(digit3), .borrow_out(b3)
  );

  // Minutes never borrow further: the count stops or reloads at zero.
  bcd_down_digit #(.MAX(MIN_MAX)) u_min (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val[19:16]),
    .dec_en(b3), .value(digit4), .borrow_out(b4)
  );

  logic unused_borrow;
  assign unused_borrow = b4;

endmodule
